sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 33 +++
 rtl/sync_fifo_param.sv | 167 ++++++++++++++++
 tb/tb_sync_fifo_param.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and sizing helpers for the synchronous FIFO.
//   FIFO_WIDTH_DFLT : default data word width
//   FIFO_DEPTH_DFLT : default number of entries
//   cnt_width()     : bits needed to hold an occupancy of 0..depth
//   ptr_width()     : bits needed to address 0..depth-1
package fifo_pkg;

  localparam int FIFO_WIDTH_DFLT = 16;
  localparam int FIFO_DEPTH_DFLT = 8;

  // Occupancy spans 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Depth is at least 2, so the result is always at least 1.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: single-clock storage array with one synchronous write port
// and one asynchronous read port. Contents are never reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write index (0..DEPTH-1)
//   wdata : write data
//   raddr : read index (0..DEPTH-1)
//   rdata : combinational read data at raddr
module fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parameterised single-clock FIFO with occupancy flags,
// registered handshake status and optional first-word-fall-through read.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   data_in     : write data
//   wr_en       : write request
//   rd_en       : read request
//   data_out    : read data (registered when FWFT=0, head view when FWFT=1)
//   wr_ack      : previous-cycle write accepted
//   overflow    : previous-cycle write rejected
//   underflow   : previous-cycle read rejected
//   full/empty/almostfull/almostempty : combinational flags from count
//   count       : current occupancy
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DFLT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DFLT,
  parameter int AFULL_LVL  = FIFO_DEPTH - 1,
  parameter int AEMPTY_LVL = 1,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [FIFO_WIDTH-1:0]               data_in,
  input  logic                                wr_en,
  input  logic                                rd_en,
  output logic [FIFO_WIDTH-1:0]               data_out,
  output logic                                wr_ack,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                full,
  output logic                                empty,
  output logic                                almostfull,
  output logic                                almostempty,
  output logic [cnt_width(FIFO_DEPTH)-1:0]    count
);

  localparam int AW = ptr_width(FIFO_DEPTH);
  localparam int CW = cnt_width(FIFO_DEPTH);

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);

  // Reject parameter combinations the control logic is not built for.
  if (FIFO_WIDTH < 1 || FIFO_WIDTH > 64) begin : g_bad_width
    $error("sync_fifo_param: FIFO_WIDTH out of range 1..64");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024) begin : g_bad_depth
    $error("sync_fifo_param: FIFO_DEPTH out of range 2..1024");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > FIFO_DEPTH - 1) begin : g_bad_afull
    $error("sync_fifo_param: AFULL_LVL out of range 1..FIFO_DEPTH-1");
  end
  if (AEMPTY_LVL < 1 || AEMPTY_LVL > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_param: AEMPTY_LVL out of range 1..FIFO_DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  rd_acc, wr_acc;
  logic                  full_s, empty_s;
  logic                  mem_we;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == CNT_ZERO);

  // Storage writes are suppressed while reset is asserted so the reset
  // cycle leaves the array untouched.
  assign mem_we = wr_acc && !rst;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // Accept decisions, pointer/count next state and registered read data.
  always_comb begin
    rd_acc   = rd_en && !empty_s;
    // A full FIFO still takes a write when a read frees a slot this cycle.
    wr_acc   = wr_en && (!full_s || rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    // Wrap by explicit compare so non-power-of-two depths work.
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_ZERO : (wr_ptr_q + PTR_ONE);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_ZERO : (rd_ptr_q + PTR_ONE);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (FWFT == 0 && rd_acc) begin
      dout_d = mem_rdata;
    end else begin
      dout_d = dout_q;
    end
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= PTR_ZERO;
      rd_ptr_q    <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      dout_q      <= {FIFO_WIDTH{1'b0}};
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en && !wr_acc;
      underflow_q <= rd_en && !rd_acc;
    end
  end

  // In fall-through mode the head entry is shown directly, zero when empty.
  assign data_out    = (FWFT != 0) ? (empty_s ? {FIFO_WIDTH{1'b0}} : mem_rdata)
                                   : dout_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = full_s;
  assign empty       = empty_s;
  assign almostfull  = (count_q >= AFULL_C) && !full_s;
  assign almostempty = (count_q <= AEMPTY_C) && !empty_s;
  assign count       = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param. Two instances: A uses defaults
// (depth 8, registered read), B uses depth 5, AFULL 3, AEMPTY 2, FWFT=1.
// The driver runs a queue-based reference model and pushes one expected
// status record per cycle; a monitor on the falling edge pops and compares.
module tb_sync_fifo_param;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        wr, rd;
  logic [15:0] din;

  logic        wr_a, rd_a, wr_b, rd_b;
  logic [15:0] dout_a, dout_b;
  logic        ack_a, ovf_a, udf_a, full_a, emp_a, af_a, ae_a;
  logic        ack_b, ovf_b, udf_b, full_b, emp_b, af_b, ae_b;
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;

  assign wr_a = wr & ~sel;
  assign rd_a = rd & ~sel;
  assign wr_b = wr & sel;
  assign rd_b = rd & sel;

  sync_fifo_param u_a (
    .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_a), .rd_en(rd_a),
    .data_out(dout_a), .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a),
    .full(full_a), .empty(emp_a), .almostfull(af_a), .almostempty(ae_a),
    .count(cnt_a)
  );

  sync_fifo_param #(
    .FIFO_DEPTH(5), .AFULL_LVL(3), .AEMPTY_LVL(2), .FWFT(1)
  ) u_b (
    .clk(clk), .rst(rst), .data_in(din), .wr_en(wr_b), .rd_en(rd_b),
    .data_out(dout_b), .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b),
    .full(full_b), .empty(emp_b), .almostfull(af_b), .almostempty(ae_b),
    .count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack, ovf, udf;
    logic        full, empty, af, ae;
    int          cnt;
    logic [15:0] dout;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mq[$];
  logic [15:0] m_dout;
  int          m_depth, m_fwft, m_af, m_ae;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the selected instance against the next expected record.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_ack",      sel ? ack_b  : ack_a,  e.ack);
      chk("overflow",    sel ? ovf_b  : ovf_a,  e.ovf);
      chk("underflow",   sel ? udf_b  : udf_a,  e.udf);
      chk("full",        sel ? full_b : full_a, e.full);
      chk("empty",       sel ? emp_b  : emp_a,  e.empty);
      chk("almostfull",  sel ? af_b   : af_a,   e.af);
      chk("almostempty", sel ? ae_b   : ae_a,   e.ae);
      chk("count",       sel ? 32'(cnt_b) : 32'(cnt_a), 32'(e.cnt));
      chk("data_out",    sel ? 32'(dout_b) : 32'(dout_a), 32'(e.dout));
    end
  end

  // One clock of stimulus; the reference model updates at the edge.
  task automatic cycle(input logic r_rst, input logic w, input logic r, input logic [15:0] d);
    exp_t        e;
    logic        rd_ok, wr_ok;
    logic [15:0] v;
    int          n;
    rst = r_rst; wr = w; rd = r; din = d;
    @(posedge clk);
    if (r_rst) begin
      mq.delete();
      m_dout = 16'h0000;
      e.ack = 1'b0; e.ovf = 1'b0; e.udf = 1'b0;
    end else begin
      rd_ok = r && (mq.size() > 0);
      wr_ok = w && ((mq.size() < m_depth) || rd_ok);
      e.ack = wr_ok;
      e.ovf = w && !wr_ok;
      e.udf = r && !rd_ok;
      if (rd_ok) begin
        v = mq.pop_front();
        if (m_fwft == 0) m_dout = v;
      end
      if (wr_ok) mq.push_back(d);
    end
    n       = mq.size();
    e.cnt   = n;
    e.full  = (n == m_depth);
    e.empty = (n == 0);
    e.af    = (n >= m_af) && (n != m_depth);
    e.ae    = (n <= m_ae) && (n != 0);
    e.dout  = (m_fwft != 0) ? ((n > 0) ? mq[0] : 16'h0000) : m_dout;
    exp_q.push_back(e);
    #2;
  endtask

  task automatic rand_phase(input int ncyc);
    int pw;
    for (int i = 0; i < ncyc; i++) begin
      pw = (i % 120 < 40) ? 75 : ((i % 120 < 80) ? 25 : 50);
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < pw),
            ($urandom_range(0, 99) < (100 - pw)),
            16'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; din = 16'h0000; sel = 1'b0;

    // ---------------- Instance A: defaults, registered read ----------
    m_depth = 8; m_fwft = 0; m_af = 7; m_ae = 1;
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i));
    cycle(1'b0, 1'b1, 1'b0, 16'h0009);          // overflow on full
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0000); // last underflows
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, 1'b0, 16'(16'h0100 + i));
    cycle(1'b0, 1'b1, 1'b1, 16'hAAAA);          // simultaneous on full
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 16'h5555);          // simultaneous on empty
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'(16'h0200 + i));
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);          // reset with count 3, inputs ignored
    cycle(1'b0, 1'b1, 1'b0, 16'hBEEF);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    rand_phase(300);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);

    // ---------------- Instance B: depth 5, fall-through ---------------
    sel = 1'b1;
    m_depth = 5; m_fwft = 1; m_af = 3; m_ae = 2;
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h1234);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);          // underflow on empty
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, (i % 3 == 2), 16'(16'h0300 + i));
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    rand_phase(300);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(negedge clk);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
